muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have no parameters; all datapaths are fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request; accepted only in IDLE.
REQ-005 kill  input  1  pipeline flush; aborts any operation in progress.
REQ-006 funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 rs1_data  input  32  operand A, taken from regfile reg_a.
REQ-008 rs2_data  input  32  operand B, taken from regfile reg_b.
REQ-009 busy  output  1  high in CALC and FIX.
REQ-010 done  output  1  one-cycle pulse, high only in DONE.
REQ-011 result  output  32  registered result; valid when done is high; held until the next accepted op completes.

Function
REQ-012 SHALL implement a four-state FSM: IDLE, CALC, FIX, DONE.
REQ-013 Acceptance: start=1, kill=0 in IDLE SHALL latch funct3, rs1_data and rs2_data; later input changes SHALL NOT affect the operation.
REQ-014 start in CALC, FIX or DONE SHALL be ignored; nothing is queued.
REQ-015 Operand sign handling:
- MULH, DIV, REM: both operands signed.
- MULHSU: rs1 signed, rs2 unsigned.
- MUL: computed unsigned.
- MULHU, DIVU, REMU: unsigned.
REQ-016 Datapath: signed operands SHALL be converted to magnitudes at acceptance; the unsigned core then runs.
REQ-017 Multiply: radix-2 shift-add, one bit per cycle, 64-bit product. MUL returns product[31:0]; MULH, MULHSU, MULHU return product[63:32] after sign correction.
REQ-018 Divide: restoring, one quotient bit per cycle, 32-bit quotient and remainder.
REQ-019 Divide signs: quotient negated if operand signs differ (signed ops only); remainder takes the dividend sign; quotient rounds toward zero.
REQ-020 Normal path timing:
- IDLE->CALC on acceptance.
- CALC lasts exactly 32 cycles, driven by a 5-bit counter 0..31.
- CALC->FIX when the counter reaches 31.
- FIX (1 cycle) applies the sign negation and selects the result.
- FIX->DONE, then DONE->IDLE unconditionally.
- done is high in the 34th cycle after the acceptance cycle.
REQ-021 Divide by zero SHALL bypass CALC and FIX: IDLE->DONE with done in the 1st cycle after acceptance.
- DIV, DIVU: result = 0xFFFFFFFF.
- REM, REMU: result = latched rs1.
REQ-022 Signed overflow (DIV or REM, rs1=0x80000000, rs2=0xFFFFFFFF) SHALL take the same bypass.
- DIV: result = 0x80000000.
- REM: result = 0.
REQ-023 kill=1 in any state SHALL force IDLE at the next edge.
- No done pulse for the aborted op; result unchanged.
- kill and start together in IDLE: kill wins and the op is not accepted.
REQ-024 A new start SHALL be accepted in the IDLE cycle immediately after DONE.
REQ-025 result SHALL update only on entry to DONE.

Reset
REQ-026 rst=1 at a clock edge SHALL force state IDLE, counter 0, busy 0, done 0, result 0x00000000, and clear all internal accumulators.
REQ-027 Reset SHALL take priority over start and kill, including mid-operation; the aborted op produces no done.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- MUL rs1=7, rs2=0xFFFFFFFD -> result 0xFFFFFFEB; done exactly 34 cycles after acceptance; busy high for cycles 1-33.
- Multiply highs -> MULH 0x80000000*0x80000000 = 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF = 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0xFFFFFFFF = 0xFFFFFFFF.
- Signed divide -> DIV 0xFFFFFFF9/2 = 0xFFFFFFFD; REM 0xFFFFFFF9/2 = 0xFFFFFFFF; DIVU 100/7 = 14; REMU 100/7 = 2.
- Bypass cases, done 1 cycle after acceptance and busy never high -> DIVU 5/0 = 0xFFFFFFFF; REM 5/0 = 5; DIV 0x80000000/0xFFFFFFFF = 0x80000000; REM same operands = 0.
- Abort and back-to-back -> kill in cycle 10 of CALC: no done, busy low next cycle, result retains prior value; a start in the following IDLE cycle completes normally; start pulses during busy are ignored.
- Reset mid-op -> rst in cycle 20 of a DIV: next cycle busy=0, done=0, result=0; no later done.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit; 34 cycles from accept to done (1 cycle for div-by-zero/overflow).
// No backpressure: start is only taken in IDLE, ignored while busy, never queued; kill aborts at the next edge.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        kill,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] b_q, b_d;
  logic [63:0] acc_q, acc_d;
  logic        neg_q, neg_d;
  logic        neg_rem_q, neg_rem_d;
  logic [31:0] result_q, result_d;

  logic        accept;
  logic        a_signed, b_signed, a_neg, b_neg;
  logic        div_zero, div_ovf, bypass;
  logic [31:0] a_mag, b_mag, bypass_res;
  logic [32:0] mul_sum;
  logic [32:0] rem_sh;
  logic [31:0] rem_sub;
  logic        rem_ge;
  logic [63:0] step;
  logic [31:0] prod_hi_neg, quot, rem, fix_res;

  // Operand decode at acceptance: magnitudes plus the signs needed to fix up the result.
  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (funct3)
      OP_MULH, OP_DIV, OP_REM: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      OP_MULHSU: a_signed = 1'b1;
      default: ;
    endcase
    a_neg    = a_signed & rs1_data[31];
    b_neg    = b_signed & rs2_data[31];
    a_mag    = a_neg ? (32'd0 - rs1_data) : rs1_data;
    b_mag    = b_neg ? (32'd0 - rs2_data) : rs2_data;
    div_zero = funct3[2] && (rs2_data == 32'd0);
    div_ovf  = ((funct3 == OP_DIV) || (funct3 == OP_REM)) &&
               (rs1_data == 32'h8000_0000) && (rs2_data == 32'hFFFF_FFFF);
    bypass   = div_zero | div_ovf;
    if (div_zero) bypass_res = funct3[1] ? rs1_data : 32'hFFFF_FFFF;
    else          bypass_res = funct3[1] ? 32'd0 : 32'h8000_0000;
  end

  // One iteration: shift-add multiply ({hi,lo} with multiplier in lo) or restoring divide ({rem,quot}).
  always_comb begin
    mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
    rem_sh  = {acc_q[63:32], acc_q[31]};
    rem_ge  = rem_sh >= {1'b0, b_q};
    // When rem_ge holds the true difference is below the divisor, so 32 bits suffice.
    rem_sub = rem_sh[31:0] - b_q;
    if (op_q[2]) step = {(rem_ge ? rem_sub : rem_sh[31:0]), acc_q[30:0], rem_ge};
    else         step = {mul_sum, acc_q[31:1]};
  end

  always_comb begin
    prod_hi_neg = ~acc_q[63:32] + {31'd0, (acc_q[31:0] == 32'd0)};
    quot        = acc_q[31:0];
    rem         = acc_q[63:32];
    case (op_q)
      OP_MUL:                      fix_res = acc_q[31:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res = neg_q ? prod_hi_neg : acc_q[63:32];
      OP_DIV, OP_DIVU:             fix_res = neg_q ? (32'd0 - quot) : quot;
      default:                     fix_res = neg_rem_q ? (32'd0 - rem) : rem;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 5'd0;
      op_q      <= 3'd0;
      b_q       <= 32'd0;
      acc_q     <= 64'd0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = bypass ? DONE : CALC;
      CALC:    if (cnt_q == 5'd31) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (kill) state_d = IDLE;
  end

  always_comb begin
    cnt_d     = cnt_q;
    op_d      = op_q;
    b_d       = b_q;
    acc_d     = acc_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    accept    = (state_q == IDLE) && start && !kill;
    if (accept) begin
      cnt_d     = 5'd0;
      op_d      = funct3;
      b_d       = b_mag;
      acc_d     = {32'd0, a_mag};
      neg_d     = a_neg ^ b_neg;
      neg_rem_d = a_neg;
      if (bypass) result_d = bypass_res;
    end else if (state_q == CALC) begin
      acc_d = step;
      cnt_d = cnt_q + 5'd1;
    end else if ((state_q == FIX) && !kill) begin
      result_d = fix_res;
    end
  end

  always_comb begin
    busy   = (state_q == CALC) || (state_q == FIX);
    done   = (state_q == DONE);
    result = result_q;
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: latency, sign handling, bypass, kill and reset behaviour.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        kill;
  logic [2:0]  funct3;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_cmp = 0;
  int n_err = 0;

  muldiv_unit dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .kill     (kill),
    .funct3   (funct3),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  always #5 clk = ~clk;

  // Called at a negedge with the unit idle; returns at the negedge of the IDLE cycle after done.
  // Operands are scrambled after the acceptance cycle so a design that fails to latch them is caught.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input bit ign, output int done_cyc, output int busy_cnt,
                        output logic [31:0] res);
    done_cyc = 0;
    busy_cnt = 0;
    res      = 32'hDEAD_BEEF;
    start    = 1'b1;
    funct3   = f;
    rs1_data = a;
    rs2_data = b;
    for (int n = 1; n <= 40 && done_cyc == 0; n++) begin
      @(negedge clk);
      start    = ign && (n >= 5) && (n < 20);
      funct3   = ~f;
      rs1_data = ~a;
      rs2_data = b ^ 32'h1;
      if (busy) busy_cnt++;
      if (done) begin
        done_cyc = n;
        res      = result;
      end
    end
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; kill = 1'b0;
    funct3 = 3'd0; rs1_data = 32'd0; rs2_data = 32'd0;
    repeat (3) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset busy: got %b expected 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset done: got %b expected 0", done); end
    n_cmp++; if (result !== 32'd0) begin n_err++; $display("FAIL reset result: got %h expected 00000000", result); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mul();
    int dc, bc;
    logic [31:0] r;
    run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 1'b0, dc, bc, r);
    n_cmp++; if (r !== 32'hFFFF_FFEB) begin n_err++; $display("FAIL mul result: got %h expected ffffffeb", r); end
    n_cmp++; if (dc != 34) begin n_err++; $display("FAIL mul done cycle: got %0d expected 34", dc); end
    n_cmp++; if (bc != 33) begin n_err++; $display("FAIL mul busy cycles: got %0d expected 33", bc); end
    n_cmp++; if (result !== 32'hFFFF_FFEB) begin n_err++; $display("FAIL mul result held: got %h expected ffffffeb", result); end
  endtask

  task automatic test_mul_high();
    logic [2:0]  f [3] = '{3'b001, 3'b011, 3'b010};
    logic [31:0] a [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] b [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] e [3] = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    int dc, bc;
    logic [31:0] r;
    for (int i = 0; i < 3; i++) begin
      run_op(f[i], a[i], b[i], 1'b0, dc, bc, r);
      n_cmp++; if (r !== e[i]) begin n_err++; $display("FAIL mulhigh[%0d] result: got %h expected %h", i, r, e[i]); end
      n_cmp++; if (dc != 34) begin n_err++; $display("FAIL mulhigh[%0d] done cycle: got %0d expected 34", i, dc); end
    end
  endtask

  task automatic test_div();
    logic [2:0]  f [4] = '{3'b100, 3'b110, 3'b101, 3'b111};
    logic [31:0] a [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
    logic [31:0] b [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
    logic [31:0] e [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
    int dc, bc;
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      run_op(f[i], a[i], b[i], 1'b0, dc, bc, r);
      n_cmp++; if (r !== e[i]) begin n_err++; $display("FAIL div[%0d] result: got %h expected %h", i, r, e[i]); end
      n_cmp++; if (dc != 34) begin n_err++; $display("FAIL div[%0d] done cycle: got %0d expected 34", i, dc); end
    end
  endtask

  task automatic test_bypass();
    logic [2:0]  f [4] = '{3'b101, 3'b110, 3'b100, 3'b110};
    logic [31:0] a [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] b [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] e [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    int dc, bc;
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      run_op(f[i], a[i], b[i], 1'b0, dc, bc, r);
      n_cmp++; if (r !== e[i]) begin n_err++; $display("FAIL bypass[%0d] result: got %h expected %h", i, r, e[i]); end
      n_cmp++; if (dc != 1) begin n_err++; $display("FAIL bypass[%0d] done cycle: got %0d expected 1", i, dc); end
      n_cmp++; if (bc != 0) begin n_err++; $display("FAIL bypass[%0d] busy cycles: got %0d expected 0", i, bc); end
    end
  endtask

  task automatic test_back_to_back();
    int dc, bc;
    logic [31:0] r;
    // start pulses during the first op must be dropped; the second op starts in the IDLE cycle after done
    run_op(3'b101, 32'd100, 32'd7, 1'b1, dc, bc, r);
    n_cmp++; if (r !== 32'd14) begin n_err++; $display("FAIL b2b first result: got %h expected 0000000e", r); end
    n_cmp++; if (dc != 34) begin n_err++; $display("FAIL b2b first done cycle: got %0d expected 34", dc); end
    n_cmp++; if (bc != 33) begin n_err++; $display("FAIL b2b first busy cycles: got %0d expected 33", bc); end
    run_op(3'b111, 32'd100, 32'd7, 1'b0, dc, bc, r);
    n_cmp++; if (r !== 32'd2) begin n_err++; $display("FAIL b2b second result: got %h expected 00000002", r); end
    n_cmp++; if (dc != 34) begin n_err++; $display("FAIL b2b second done cycle: got %0d expected 34", dc); end
    n_cmp++; if (bc != 33) begin n_err++; $display("FAIL b2b second busy cycles: got %0d expected 33", bc); end
  endtask

  task automatic test_kill();
    int dc, bc, dn;
    logic [31:0] r;
    run_op(3'b101, 32'd100, 32'd7, 1'b0, dc, bc, r);
    n_cmp++; if (r !== 32'd14) begin n_err++; $display("FAIL kill setup result: got %h expected 0000000e", r); end
    start = 1'b1; funct3 = 3'b000; rs1_data = 32'd3; rs2_data = 32'd5;
    dn = 0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) dn++;
    end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL kill calc busy: got %b expected 1", busy); end
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    if (done) dn++;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL kill busy after: got %b expected 0", busy); end
    n_cmp++; if (dn != 0) begin n_err++; $display("FAIL kill done pulses: got %0d expected 0", dn); end
    n_cmp++; if (result !== 32'd14) begin n_err++; $display("FAIL kill result kept: got %h expected 0000000e", result); end
    run_op(3'b011, 32'hFFFF_FFFF, 32'd2, 1'b0, dc, bc, r);
    n_cmp++; if (r !== 32'd1) begin n_err++; $display("FAIL post-kill result: got %h expected 00000001", r); end
    n_cmp++; if (dc != 34) begin n_err++; $display("FAIL post-kill done cycle: got %0d expected 34", dc); end
    n_cmp++; if (bc != 33) begin n_err++; $display("FAIL post-kill busy cycles: got %0d expected 33", bc); end
    // kill and start together in IDLE: the op must not be accepted
    start = 1'b1; kill = 1'b1; funct3 = 3'b000; rs1_data = 32'd3; rs2_data = 32'd5;
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL kill+start busy: got %b expected 0", busy); end
    dn = 0;
    repeat (36) begin
      if (done) dn++;
      @(negedge clk);
    end
    n_cmp++; if (dn != 0) begin n_err++; $display("FAIL kill+start done pulses: got %0d expected 0", dn); end
    n_cmp++; if (result !== 32'd1) begin n_err++; $display("FAIL kill+start result: got %h expected 00000001", result); end
  endtask

  task automatic test_reset_mid_op();
    int dn;
    start = 1'b1; funct3 = 3'b100; rs1_data = 32'd100; rs2_data = 32'd7;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst-mid busy: got %b expected 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rst-mid done: got %b expected 0", done); end
    n_cmp++; if (result !== 32'd0) begin n_err++; $display("FAIL rst-mid result: got %h expected 00000000", result); end
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dn++;
    end
    n_cmp++; if (dn != 0) begin n_err++; $display("FAIL rst-mid later done: got %0d expected 0", dn); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mul_high();
    test_div();
    test_bypass();
    test_back_to_back();
    test_kill();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
